// File: rtl/stack_ctrl.sv
// stack_ctrl: initiator side of a single-port stack RAM.
// Keeps the top of stack in a register and the stack pointer in COUNT.
// It drives the RAM's CS/WE/ADDRESS/data_in pins from posedge registers.
// The RAM samples those pins and updates data_out on the negedge.
//
// Handshake: a command transfers on a CLK posedge where CMD_VALID && CMD_READY.
// CMD_READY is high only while the FSM is idle. CMD and DATA_IN need only be
// stable around that edge. Every accepted command is consumed, including the
// ones that only raise an error flag.
module stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CMD_VALID,
    input  logic [1:0]        CMD,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic              CMD_READY,
    output logic [DATA_W-1:0] TOP_DATA,
    output logic [DATA_W-1:0] POP_DATA,
    output logic              POP_VALID,
    output logic [ADDR_W:0]   COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT,
    output logic [1:0]        DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_POP   = 2'b01;
    localparam logic [1:0] CMD_DUP   = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_TWO   = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_m2;
    logic [DATA_W-1:0] top;

    // Address of the entry that becomes the new top after a pop.
    // That entry sits two below the current count.
    assign count_m2 = count - CNT_TWO;

    assign CMD_READY = (state == IDLE);
    assign COUNT     = count;
    assign TOP_DATA  = top;
    assign EMPTY     = (count == '0);
    assign FULL      = (count == CNT_DEPTH);
    assign DBG_STATE = state;

    // Command FSM, stack pointer, top-of-stack cache and registered RAM pins.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            count     <= '0;
            top       <= '0;
            POP_DATA  <= '0;
            POP_VALID <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            MEM_CS    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_DIN   <= '0;
        end else begin
            POP_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        case (CMD)
                            CMD_PUSH: begin
                                if (FULL) begin
                                    OVERFLOW <= 1'b1;
                                end else begin
                                    MEM_CS   <= 1'b1;
                                    MEM_WE   <= 1'b1;
                                    MEM_ADDR <= count[ADDR_W-1:0];
                                    MEM_DIN  <= DATA_IN;
                                    top      <= DATA_IN;
                                    count    <= count + CNT_ONE;
                                    state    <= WRITE;
                                end
                            end
                            CMD_DUP: begin
                                if (EMPTY) begin
                                    UNDERFLOW <= 1'b1;
                                end else if (FULL) begin
                                    OVERFLOW <= 1'b1;
                                end else begin
                                    MEM_CS   <= 1'b1;
                                    MEM_WE   <= 1'b1;
                                    MEM_ADDR <= count[ADDR_W-1:0];
                                    MEM_DIN  <= top;
                                    count    <= count + CNT_ONE;
                                    state    <= WRITE;
                                end
                            end
                            CMD_POP: begin
                                if (EMPTY) begin
                                    UNDERFLOW <= 1'b1;
                                end else begin
                                    POP_DATA  <= top;
                                    POP_VALID <= 1'b1;
                                    count     <= count - CNT_ONE;
                                    if (count > CNT_ONE) begin
                                        MEM_CS   <= 1'b1;
                                        MEM_WE   <= 1'b0;
                                        MEM_ADDR <= count_m2[ADDR_W-1:0];
                                        state    <= READ;
                                    end else begin
                                        top <= '0;
                                    end
                                end
                            end
                            default: begin
                                count     <= '0;
                                top       <= '0;
                                OVERFLOW  <= 1'b0;
                                UNDERFLOW <= 1'b0;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    MEM_CS <= 1'b0;
                    MEM_WE <= 1'b0;
                    state  <= IDLE;
                end
                READ: begin
                    top    <= MEM_DOUT;
                    MEM_CS <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    MEM_CS <= 1'b0;
                    MEM_WE <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl. It contains a behavioural 128x8 RAM that works on the
// negedge. It also keeps a queue model of the stack contents.
module tb_stack_ctrl;

    localparam logic [1:0] C_PUSH  = 2'b00;
    localparam logic [1:0] C_POP   = 2'b01;
    localparam logic [1:0] C_DUP   = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       CMD_VALID;
    logic [1:0] CMD;
    logic [7:0] DATA_IN;
    logic       CMD_READY;
    logic [7:0] TOP_DATA;
    logic [7:0] POP_DATA;
    logic       POP_VALID;
    logic [7:0] COUNT;
    logic       EMPTY;
    logic       FULL;
    logic       OVERFLOW;
    logic       UNDERFLOW;
    logic       MEM_CS;
    logic       MEM_WE;
    logic [6:0] MEM_ADDR;
    logic [7:0] MEM_DIN;
    logic [7:0] MEM_DOUT;
    logic [1:0] DBG_STATE;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: exp_q holds the stack from bottom to top.
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic       exp_unf;
    logic [7:0] exp_pop_data;

    logic [7:0] ram [0:127];

    stack_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .DATA_IN(DATA_IN), .CMD_READY(CMD_READY), .TOP_DATA(TOP_DATA),
        .POP_DATA(POP_DATA), .POP_VALID(POP_VALID), .COUNT(COUNT),
        .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
        .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT), .DBG_STATE(DBG_STATE)
    );

    // Clock.
    always #5 CLK = ~CLK;

    // Single-port RAM: samples its pins and registers data_out on the negedge.
    always @(negedge CLK) begin
        if (MEM_CS) begin
            if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
            else        MEM_DOUT <= ram[MEM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_top();
        if (exp_q.size() == 0) return 8'h00;
        return exp_q[exp_q.size()-1];
    endfunction

    // Compares every architectural output with the model once the command has completed.
    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ".count"}, COUNT, n);
        chk({tag, ".top"}, TOP_DATA, exp_top());
        chk({tag, ".empty"}, EMPTY, n == 0);
        chk({tag, ".full"}, FULL, n == 128);
        chk({tag, ".ovf"}, OVERFLOW, exp_ovf);
        chk({tag, ".unf"}, UNDERFLOW, exp_unf);
        chk({tag, ".pop_data"}, POP_DATA, exp_pop_data);
        chk({tag, ".mem_cs_idle"}, MEM_CS, 1'b0);
        if (n > 0) begin
            chk({tag, ".ram_top"}, ram[n-1], exp_q[n-1]);
            chk({tag, ".ram_bottom"}, ram[0], exp_q[0]);
        end
    endtask

    // Sends one command and applies the stack rules to the model.
    // It checks the cycle right after acceptance, then the busy length, then the final state.
    task automatic issue(input string tag, input logic [1:0] c, input logic [7:0] d);
        int  n;
        int  exp_busy;
        int  busy;
        logic exp_pv;
        logic exp_access;
        logic exp_we;
        int  exp_addr;
        n = exp_q.size();
        exp_busy = 0; exp_pv = 1'b0; exp_access = 1'b0; exp_we = 1'b0; exp_addr = 0;
        case (c)
            C_PUSH: begin
                if (n == 128) exp_ovf = 1'b1;
                else begin
                    exp_access = 1'b1; exp_we = 1'b1; exp_addr = n; exp_busy = 1;
                    exp_q.push_back(d);
                end
            end
            C_DUP: begin
                if (n == 0) exp_unf = 1'b1;
                else if (n == 128) exp_ovf = 1'b1;
                else begin
                    exp_access = 1'b1; exp_we = 1'b1; exp_addr = n; exp_busy = 1;
                    exp_q.push_back(exp_q[n-1]);
                end
            end
            C_POP: begin
                if (n == 0) exp_unf = 1'b1;
                else begin
                    exp_pv = 1'b1;
                    exp_pop_data = exp_q.pop_back();
                    if (n > 1) begin
                        exp_access = 1'b1; exp_addr = n - 2; exp_busy = 1;
                    end
                end
            end
            default: begin
                exp_q.delete();
                exp_ovf = 1'b0;
                exp_unf = 1'b0;
            end
        endcase
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD = c; DATA_IN = d;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0; DATA_IN = $urandom_range(0, 255);
        chk({tag, ".pop_valid"}, POP_VALID, exp_pv);
        if (exp_pv) chk({tag, ".pop_data_now"}, POP_DATA, exp_pop_data);
        chk({tag, ".mem_cs"}, MEM_CS, exp_access);
        if (exp_access) begin
            chk({tag, ".mem_we"}, MEM_WE, exp_we);
            chk({tag, ".mem_addr"}, MEM_ADDR, exp_addr);
            if (exp_we) chk({tag, ".mem_din"}, MEM_DIN, exp_q[exp_q.size()-1]);
        end
        busy = 0;
        while (!CMD_READY && busy < 10) begin
            @(posedge CLK); #1;
            busy++;
        end
        chk({tag, ".busy_cycles"}, busy, exp_busy);
        check_state(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_pop_data = 8'h00;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".ready"}, CMD_READY, 1'b1);
        chk({tag, ".count"}, COUNT, 0);
        chk({tag, ".top"}, TOP_DATA, 0);
        chk({tag, ".pop_data"}, POP_DATA, 0);
        chk({tag, ".pop_valid"}, POP_VALID, 0);
        chk({tag, ".ovf"}, OVERFLOW, 0);
        chk({tag, ".unf"}, UNDERFLOW, 0);
        chk({tag, ".empty"}, EMPTY, 1);
        chk({tag, ".full"}, FULL, 0);
        chk({tag, ".mem_cs"}, MEM_CS, 0);
        chk({tag, ".mem_we"}, MEM_WE, 0);
        chk({tag, ".mem_addr"}, MEM_ADDR, 0);
        chk({tag, ".mem_din"}, MEM_DIN, 0);
    endtask

    initial begin
        int r;
        RESET_N = 1'b0; CMD_VALID = 1'b0; CMD = 2'b00; DATA_IN = 8'h00;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("reset");
        RESET_N = 1'b1;

        // Basic push/pop order, last pop without a read, and underflow.
        issue("push11", C_PUSH, 8'h11);
        issue("push22", C_PUSH, 8'h22);
        issue("push33", C_PUSH, 8'h33);
        chk("ram1", ram[1], 8'h22);
        issue("pop1", C_POP, 8'h00);
        issue("pop2", C_POP, 8'h00);
        issue("pop3", C_POP, 8'h00);
        issue("pop_underflow", C_POP, 8'h00);
        issue("dup_empty", C_DUP, 8'h00);

        // Fill to capacity, overflow via PUSH and DUP, then CLEAR.
        issue("clear0", C_CLEAR, 8'h00);
        for (int i = 0; i < 128; i++) issue("fill", C_PUSH, 8'(i));
        issue("push_full", C_PUSH, 8'hAA);
        issue("dup_full", C_DUP, 8'h00);
        chk("ram0_kept", ram[0], 8'h00);
        issue("clear_full", C_CLEAR, 8'h00);

        // DUP, then pop back to the original entry through a read of address 0.
        issue("push05", C_PUSH, 8'h05);
        issue("dup05", C_DUP, 8'h00);
        chk("ram1_dup", ram[1], 8'h05);
        issue("pop_dup", C_POP, 8'h00);

        // Reset while a pop's read is in flight.
        issue("push44", C_PUSH, 8'h44);
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD = C_POP;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        chk("midrst.read_issued", MEM_CS, 1'b1);
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        check_reset_values("midrst");
        RESET_N = 1'b1;
        model_reset();
        issue("push7f_after_rst", C_PUSH, 8'h7F);
        chk("ram0_7f", ram[0], 8'h7F);

        // Randomized command mix.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 19);
            if (r < 9)       issue("rnd_push", C_PUSH, 8'($urandom_range(0, 255)));
            else if (r < 16) issue("rnd_pop", C_POP, 8'h00);
            else if (r < 19) issue("rnd_dup", C_DUP, 8'h00);
            else             issue("rnd_clear", C_CLEAR, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
